pattern_serializer: RTL and testbench

//   Parametrised waveform generator. Holds a DEPTH x WIDTH pattern RAM, shifts it out one bit per

---
 rtl/pattern_serializer_if.sv | 30 +++
 rtl/pattern_serializer.sv | 111 +++++++++++
 tb/tb_pattern_serializer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_serializer_if.sv
// Host/config port and serial-stream outputs of the pattern serializer.
interface pattern_serializer_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              start;
   logic              stop;
   logic              loop;
   logic [ADDR_W-1:0] last_addr;
   logic              op_wave;
   logic              op_valid;
   logic              word_done;
   logic              busy;
   logic              done;

   // Host side: drives writes and control, observes the stream.
   modport master (
      output wr_en, wr_addr, wr_data, start, stop, loop, last_addr,
      input  op_wave, op_valid, word_done, busy, done
   );

   // Serializer side.
   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, loop, last_addr,
      output op_wave, op_valid, word_done, busy, done
   );
endinterface

// File: rtl/pattern_serializer.sv
// Pattern RAM shifted out one bit per clock, with start/stop, end word,
// loop/one-shot and selectable bit order.
module pattern_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input logic                 clock,
   input logic                 reset,
   pattern_serializer_if.slave bus
);

   localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   logic [WIDTH-1:0]  mem [DEPTH];

   state_e            state_q, state_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [ADDR_W-1:0] word_q, word_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic              loop_q, loop_d;
   logic              done_q, done_d;

   logic              run;
   logic              bit_end;
   logic [BIT_W-1:0]  sel;
   logic [WIDTH-1:0]  rd_word;

   // Pattern RAM write port; contents are intentionally not reset.
   always_ff @(posedge clock) begin
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
   end

   assign run     = (state_q == ST_RUN);
   assign bit_end = (bit_q == BIT_LAST);
   assign sel     = MSB_FIRST ? (BIT_LAST - bit_q) : bit_q;
   assign rd_word = mem[word_q];

   // Next-state: playback control, bit/word counters, end-of-sequence handling.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      word_d  = word_q;
      last_d  = last_q;
      loop_d  = loop_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d = ST_RUN;
               bit_d   = '0;
               word_d  = '0;
               last_d  = bus.last_addr;
               loop_d  = bus.loop;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               // Abort wins over end-of-sequence: no done pulse.
               state_d = ST_IDLE;
            end else if (bit_end) begin
               bit_d = '0;
               if (word_q == last_q) begin
                  if (loop_q) begin
                     word_d = '0;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  word_d = word_q + ADDR_W'(1);
               end
            end else begin
               bit_d = bit_q + BIT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         bit_q   <= '0;
         word_q  <= '0;
         last_q  <= '0;
         loop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         last_q  <= last_d;
         loop_q  <= loop_d;
         done_q  <= done_d;
      end
   end

   // Outputs decode straight from registers so a RAM write shows up next cycle.
   assign bus.busy      = run;
   assign bus.op_valid  = run;
   assign bus.word_done = run && bit_end;
   assign bus.op_wave   = run && rd_word[sel];
   assign bus.done      = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed self-checking bench for pattern_serializer (three configurations).
module tb_pattern_serializer;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clock = ~clock;

   pattern_serializer_if #(.WIDTH(8), .ADDR_W(4)) bus_a ();
   pattern_serializer_if #(.WIDTH(8), .ADDR_W(4)) bus_m ();
   pattern_serializer_if #(.WIDTH(4), .ADDR_W(2)) bus_s ();

   pattern_serializer #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .MSB_FIRST(1'b0)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a));
   pattern_serializer #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .MSB_FIRST(1'b1)) dut_m (
      .clock(clock), .reset(reset), .bus(bus_m));
   pattern_serializer #(.WIDTH(4), .DEPTH(4), .ADDR_W(2), .MSB_FIRST(1'b0)) dut_s (
      .clock(clock), .reset(reset), .bus(bus_s));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_a(input logic [3:0] addr, input logic [7:0] data);
      bus_a.wr_en = 1'b1; bus_a.wr_addr = addr; bus_a.wr_data = data;
      tick();
      bus_a.wr_en = 1'b0;
   endtask

   task automatic start_a(input logic [3:0] last, input logic lp);
      bus_a.last_addr = last; bus_a.loop = lp; bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      reset = 1'b1;
      #1;
      got = {bus_a.busy, bus_a.op_valid, bus_a.op_wave, bus_a.word_done, bus_a.done};
      tests_run++;
      if (got !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_a outputs got=%b exp=00000", got);
      end
      got = {bus_m.busy, bus_m.op_valid, bus_m.op_wave, bus_m.word_done, bus_m.done};
      tests_run++;
      if (got !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_m outputs got=%b exp=00000", got);
      end
      got = {bus_s.busy, bus_s.op_valid, bus_s.op_wave, bus_s.word_done, bus_s.done};
      tests_run++;
      if (got !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_s outputs got=%b exp=00000", got);
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // 0xCC then 0xAA, LSB first, one-shot over two words.
   task automatic test_one_shot();
      logic [15:0] bits = {8'hAA, 8'hCC};
      logic [3:0]  got, exp;
      write_a(4'd0, 8'hCC);
      write_a(4'd1, 8'hAA);
      start_a(4'd1, 1'b0);
      for (int c = 1; c <= 16; c++) begin
         got = {bus_a.op_valid, bus_a.op_wave, bus_a.word_done, bus_a.done};
         exp = {1'b1, bits[c-1], (c % 8) == 0, 1'b0};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL one_shot cycle %0d got=%b exp=%b", c, got, exp);
         end
         tick();
      end
      got = {bus_a.busy, bus_a.op_valid, bus_a.op_wave, bus_a.done};
      tests_run++;
      if (got !== 4'b0001) begin
         tests_failed++;
         $display("FAIL one_shot_done cycle 17 got=%b exp=0001", got);
      end
      tick();
      tests_run++;
      if (bus_a.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL one_shot_done_width got=%b exp=0", bus_a.done);
      end
   endtask

   // Single-word loop, then stop: gapless repetition, no done.
   task automatic test_loop_stop();
      logic [3:0] got, exp;
      write_a(4'd0, 8'h01);
      start_a(4'd0, 1'b1);
      bus_a.loop = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         got = {bus_a.op_valid, bus_a.op_wave, bus_a.word_done, bus_a.done};
         exp = {1'b1, (c % 8) == 1, (c % 8) == 0, 1'b0};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL loop cycle %0d got=%b exp=%b", c, got, exp);
         end
         tick();
      end
      bus_a.stop = 1'b1;
      tick();
      bus_a.stop = 1'b0;
      for (int c = 0; c < 3; c++) begin
         got = {bus_a.busy, bus_a.op_valid, bus_a.op_wave, bus_a.done};
         tests_run++;
         if (got !== 4'b0) begin
            tests_failed++;
            $display("FAIL loop_stop cycle +%0d got=%b exp=0000", c + 1, got);
         end
         tick();
      end
   endtask

   task automatic test_msb_first();
      logic [3:0] got, exp;
      bus_m.wr_en = 1'b1; bus_m.wr_addr = 4'd0; bus_m.wr_data = 8'h80;
      tick();
      bus_m.wr_en = 1'b0;
      bus_m.last_addr = 4'd0; bus_m.loop = 1'b0; bus_m.start = 1'b1;
      tick();
      bus_m.start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         got = {bus_m.op_valid, bus_m.op_wave, bus_m.word_done, bus_m.done};
         exp = (c == 9) ? 4'b0001 : {1'b1, c == 1, c == 8, 1'b0};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL msb_first cycle %0d got=%b exp=%b", c, got, exp);
         end
         tick();
      end
   endtask

   // Async reset at word 2 bit 3, then a restart from word 0 bit 0.
   task automatic test_async_reset();
      logic [7:0] cc = 8'hCC;
      logic [3:0] got, exp;
      write_a(4'd0, 8'hCC);
      write_a(4'd1, 8'hAA);
      write_a(4'd2, 8'hFF);
      write_a(4'd3, 8'h00);
      start_a(4'd3, 1'b0);
      repeat (19) tick();
      got = {bus_a.busy, bus_a.op_valid, bus_a.op_wave, bus_a.word_done};
      tests_run++;
      if (got !== 4'b1110) begin
         tests_failed++;
         $display("FAIL areset_pre got=%b exp=1110", got);
      end
      #2;
      reset = 1'b1;
      #1;
      got = {bus_a.busy, bus_a.op_valid, bus_a.op_wave, bus_a.word_done};
      tests_run++;
      if (got !== 4'b0000) begin
         tests_failed++;
         $display("FAIL areset_drop got=%b exp=0000", got);
      end
      #1;
      reset = 1'b0;
      tick();
      start_a(4'd0, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         got = {bus_a.op_valid, bus_a.op_wave, bus_a.word_done, bus_a.done};
         exp = (c == 9) ? 4'b0001 : {1'b1, cc[c-1], c == 8, 1'b0};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL areset_replay cycle %0d got=%b exp=%b", c, got, exp);
         end
         tick();
      end
   endtask

   task automatic test_controls();
      logic [15:0] bits = {8'hAA, 8'hCC};
      logic [7:0]  cc = 8'hCC;
      logic [7:0]  n33 = 8'h33;
      logic [3:0]  got, exp;
      logic        eb;
      // start and stop together while idle
      bus_a.start = 1'b1; bus_a.stop = 1'b1;
      tick();
      bus_a.start = 1'b0; bus_a.stop = 1'b0;
      got = {bus_a.busy, bus_a.op_valid, bus_a.op_wave, bus_a.done};
      tests_run++;
      if (got !== 4'b0) begin
         tests_failed++;
         $display("FAIL start_stop_idle got=%b exp=0000", got);
      end
      // start re-pulsed during a run must not disturb it
      start_a(4'd1, 1'b0);
      for (int c = 1; c <= 17; c++) begin
         got = {bus_a.op_valid, bus_a.op_wave, bus_a.word_done, bus_a.done};
         exp = (c == 17) ? 4'b0001 : {1'b1, bits[c-1], (c % 8) == 0, 1'b0};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL start_in_run cycle %0d got=%b exp=%b", c, got, exp);
         end
         bus_a.start = (c == 5 || c == 11);
         tick();
      end
      bus_a.start = 1'b0;
      tick();
      // rewrite of the word being played, mid-word
      start_a(4'd0, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         eb  = (c <= 3) ? cc[c-1] : n33[c-1];
         got = {bus_a.op_valid, bus_a.op_wave, bus_a.word_done, bus_a.done};
         exp = (c == 9) ? 4'b0001 : {1'b1, eb, c == 8, 1'b0};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL midword_write cycle %0d got=%b exp=%b", c, got, exp);
         end
         bus_a.wr_en = (c == 3); bus_a.wr_addr = 4'd0; bus_a.wr_data = 8'h33;
         tick();
      end
      bus_a.wr_en = 1'b0;
      // stop on the final bit beats end-of-sequence: no done
      write_a(4'd0, 8'hCC);
      start_a(4'd0, 1'b0);
      repeat (7) tick();
      bus_a.stop = 1'b1;
      tick();
      bus_a.stop = 1'b0;
      got = {bus_a.busy, bus_a.op_valid, bus_a.op_wave, bus_a.done};
      tests_run++;
      if (got !== 4'b0) begin
         tests_failed++;
         $display("FAIL stop_vs_end got=%b exp=0000", got);
      end
   endtask

   // 4x4 instance playing the whole RAM one-shot.
   task automatic test_small();
      int n_valid = 0, n_wd = 0, n_done = 0, n_ones = 0;
      logic [15:0] wave_seq = '0;
      for (int a = 0; a < 4; a++) begin
         bus_s.wr_en = 1'b1; bus_s.wr_addr = 2'(a); bus_s.wr_data = 4'(1 << a);
         tick();
      end
      bus_s.wr_en = 1'b0;
      bus_s.last_addr = 2'd3; bus_s.loop = 1'b0; bus_s.start = 1'b1;
      tick();
      bus_s.start = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         if (bus_s.op_valid === 1'b1) n_valid++;
         if (bus_s.word_done === 1'b1) n_wd++;
         if (bus_s.done === 1'b1) n_done++;
         if (bus_s.op_wave === 1'b1) n_ones++;
         if (c <= 16) wave_seq[c-1] = bus_s.op_wave;
         tick();
      end
      tests_run++;
      if (n_valid != 16) begin
         tests_failed++;
         $display("FAIL small_valid_count got=%0d exp=16", n_valid);
      end
      tests_run++;
      if (n_wd != 4) begin
         tests_failed++;
         $display("FAIL small_word_done_count got=%0d exp=4", n_wd);
      end
      tests_run++;
      if (n_done != 1) begin
         tests_failed++;
         $display("FAIL small_done_count got=%0d exp=1", n_done);
      end
      tests_run++;
      if (n_ones != 4 || wave_seq !== 16'h8421) begin
         tests_failed++;
         $display("FAIL small_wave got=%h ones=%0d exp=8421 ones=4", wave_seq, n_ones);
      end
   endtask

   initial begin
      bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
      bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop = 1'b0; bus_a.last_addr = '0;
      bus_m.wr_en = 1'b0; bus_m.wr_addr = '0; bus_m.wr_data = '0;
      bus_m.start = 1'b0; bus_m.stop = 1'b0; bus_m.loop = 1'b0; bus_m.last_addr = '0;
      bus_s.wr_en = 1'b0; bus_s.wr_addr = '0; bus_s.wr_data = '0;
      bus_s.start = 1'b0; bus_s.stop = 1'b0; bus_s.loop = 1'b0; bus_s.last_addr = '0;
      test_reset();
      test_one_shot();
      test_loop_stop();
      test_msb_first();
      test_async_reset();
      test_controls();
      test_small();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
